// File: rtl/sobel_pkg.sv
// sobel_pkg
//   Shared constants and types for the Sobel gradient-magnitude front end.
//   The default widths match the standard build (8-bit pixels, 640-pixel lines,
//   18-bit sum of squares). Modules that take these values as parameters use the
//   constants below only as their defaults.
//   Optional feature macro used by the top level: SOBEL_BORDER_ZERO_EN.
package sobel_pkg;

    localparam int SOBEL_IMG_WIDTH     = 640;
    localparam int SOBEL_COLOR_CHANNEL = 8;
    localparam int SOBEL_DATA_SIZE     = 17;
    localparam int SOBEL_SHIFT         = 2;
    localparam int SOBEL_GRAD_W        = SOBEL_COLOR_CHANNEL + 3;

    // Cycles from the edge that accepts a pixel to the cycle its result is visible,
    // counted as in "pixel presented in cycle T, result in cycle T+5".
    localparam int SOBEL_LATENCY = 5;

    typedef logic        [SOBEL_COLOR_CHANNEL-1:0]   pixel_t;
    typedef logic signed [SOBEL_GRAD_W-1:0]          grad_t;
    typedef logic        [SOBEL_COLOR_CHANNEL-1:0]   mag_t;
    typedef logic        [2*SOBEL_COLOR_CHANNEL-1:0] sq_t;
    typedef logic        [SOBEL_DATA_SIZE:0]         sum_t;

    // Address width for a RAM of the given depth; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer
//   One image line of pixel storage. Read is asynchronous, so a read and a
//   write to the same address in the same cycle return the old contents and
//   store the new value at the clock edge. Contents are never cleared.
// Ports
//   clk      in   1       clock
//   wr_en    in   1       store wr_data at addr on this edge
//   addr     in   AW      column address (read and write)
//   wr_data  in   WIDTH   value to store
//   rd_data  out  WIDTH   current contents at addr
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = SOBEL_IMG_WIDTH,
    parameter int WIDTH = SOBEL_COLOR_CHANNEL,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_sum_squares.sv
// sobel_sum_squares
//   Streaming Sobel front end: keeps two line buffers and a 3x3 window over a
//   raster pixel stream, computes Gx/Gy, scales and clamps |G|, squares both
//   terms and emits Gx'^2 + Gy'^2. Fixed latency: result visible 5 cycles after
//   the cycle in which the pixel completing its window was presented.
//   Optional feature macro: SOBEL_BORDER_ZERO_EN. When defined, every accepted
//   pixel of a synchronised frame produces one result, border windows giving 0.
//   When undefined, only full windows (row>=2, col>=2) produce results.
// Ports
//   i_clk          in   1              clock
//   i_reset_n      in   1              asynchronous active-low reset
//   i_pixel        in   COLOR_CHANNEL  pixel, raster order
//   i_pixel_ready  in   1              i_pixel valid this cycle
//   i_frame_start  in   1              first pixel of a frame (qualified by i_pixel_ready)
//   o_data         out  DATA_SIZE+1    Gx'^2 + Gy'^2, held between results
//   o_data_ready   out  1              single-cycle result strobe
module sobel_sum_squares
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH     = SOBEL_IMG_WIDTH,
    parameter int COLOR_CHANNEL = SOBEL_COLOR_CHANNEL,
    parameter int DATA_SIZE     = SOBEL_DATA_SIZE,
    parameter int SHIFT         = SOBEL_SHIFT
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [COLOR_CHANNEL-1:0] i_pixel,
    input  logic                     i_pixel_ready,
    input  logic                     i_frame_start,
    output logic [DATA_SIZE:0]       o_data,
    output logic                     o_data_ready
);

    localparam int AW     = addr_w(IMG_WIDTH);
    localparam int CC     = COLOR_CHANNEL;
    localparam int GRAD_W = COLOR_CHANNEL + 3;
    localparam int SQ_W   = 2 * COLOR_CHANNEL;
    localparam int OUT_W  = DATA_SIZE + 1;

    localparam logic [AW-1:0] COL_LAST = AW'(IMG_WIDTH - 1);
    localparam logic [AW-1:0] COL_MIN  = AW'(2);

    // Zero-extend a pixel into the signed gradient width.
    function automatic logic signed [GRAD_W-1:0] ext(input logic [CC-1:0] p);
        return {3'b000, p};
    endfunction

    // |g| >> SHIFT, saturated to the largest pixel value.
    function automatic logic [CC-1:0] sat_mag(input logic signed [GRAD_W-1:0] g);
        logic [GRAD_W-1:0] a;
        a = (g < 0) ? -g : g;
        a = a >> SHIFT;
        if (|a[GRAD_W-1:CC]) begin
            return '1;
        end
        return a[CC-1:0];
    endfunction

    function automatic logic [SQ_W-1:0] square(input logic [CC-1:0] m);
        logic [SQ_W-1:0] w;
        w = {{CC{1'b0}}, m};
        return w * w;
    endfunction

    function automatic logic [OUT_W-1:0] sum_sq(input logic [SQ_W-1:0] x,
                                                input logic [SQ_W-1:0] y);
        logic [OUT_W-1:0] a;
        logic [OUT_W-1:0] b;
        a = OUT_W'(x);
        b = OUT_W'(y);
        return a + b;
    endfunction

    logic          accept;
    logic [AW-1:0] col_q;
    logic [AW-1:0] cur_col;
    logic [1:0]    row_q;
    logic [1:0]    cur_row;
    logic          synced_q;
    logic          synced_now;
    logic          win_valid;

    logic [CC-1:0] lb0_rd;
    logic [CC-1:0] lb1_rd;

    logic [CC-1:0] win_p0 [3][3];
    logic          vld_p0;
    logic          vld_p1;
    logic          vld_p2;
    logic          vld_p3;
`ifdef SOBEL_BORDER_ZERO_EN
    logic          zero_p0;
`endif

    logic signed [GRAD_W-1:0] gx_c;
    logic signed [GRAD_W-1:0] gy_c;
    logic signed [GRAD_W-1:0] gx_p1;
    logic signed [GRAD_W-1:0] gy_p1;
    logic [CC-1:0]            mx_p2;
    logic [CC-1:0]            my_p2;
    logic [SQ_W-1:0]          sx_p3;
    logic [SQ_W-1:0]          sy_p3;

    assign accept = i_pixel_ready;

    // Position of the pixel being accepted this cycle. Row saturates at 2 since
    // only "at least two lines above exist" matters. Results are suppressed after
    // reset until a frame start re-establishes the raster position.
    always_comb begin
        cur_col = col_q;
        cur_row = row_q;
        if (i_frame_start) begin
            cur_col = '0;
            cur_row = 2'd0;
        end else if (col_q == COL_LAST) begin
            cur_col = '0;
            cur_row = (row_q == 2'd2) ? 2'd2 : row_q + 2'd1;
        end else begin
            cur_col = col_q + AW'(1);
        end
        synced_now = synced_q | i_frame_start;
        win_valid  = synced_now && (cur_row == 2'd2) && (cur_col >= COL_MIN);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            col_q    <= '0;
            row_q    <= 2'd0;
            synced_q <= 1'b0;
        end else if (accept) begin
            col_q    <= cur_col;
            row_q    <= cur_row;
            synced_q <= synced_now;
        end
    end

    // lb0 holds the previous line, lb1 the line before it; lb1 is refilled from
    // lb0's old contents as the current line overwrites lb0.
    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (CC)
    ) u_lb0 (
        .clk     (i_clk),
        .wr_en   (accept),
        .addr    (cur_col),
        .wr_data (i_pixel),
        .rd_data (lb0_rd)
    );

    sobel_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (CC)
    ) u_lb1 (
        .clk     (i_clk),
        .wr_en   (accept),
        .addr    (cur_col),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // ---- S0: window register (row 0 = oldest line, column 2 = newest) ----
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_p0[r][c] <= '0;
                end
            end
            vld_p0 <= 1'b0;
`ifdef SOBEL_BORDER_ZERO_EN
            zero_p0 <= 1'b0;
`endif
        end else begin
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_p0[r][0] <= win_p0[r][1];
                    win_p0[r][1] <= win_p0[r][2];
                end
                win_p0[0][2] <= lb1_rd;
                win_p0[1][2] <= lb0_rd;
                win_p0[2][2] <= i_pixel;
            end
`ifdef SOBEL_BORDER_ZERO_EN
            vld_p0  <= accept && synced_now;
            zero_p0 <= !win_valid;
`else
            vld_p0  <= accept && win_valid;
`endif
        end
    end

    always_comb begin
        gx_c = (ext(win_p0[0][2]) + (ext(win_p0[1][2]) <<< 1) + ext(win_p0[2][2]))
             - (ext(win_p0[0][0]) + (ext(win_p0[1][0]) <<< 1) + ext(win_p0[2][0]));
        gy_c = (ext(win_p0[2][0]) + (ext(win_p0[2][1]) <<< 1) + ext(win_p0[2][2]))
             - (ext(win_p0[0][0]) + (ext(win_p0[0][1]) <<< 1) + ext(win_p0[0][2]));
    end

    // ---- S1..S3: gradients, scaled magnitudes, squares ----
    always_ff @(posedge i_clk) begin
`ifdef SOBEL_BORDER_ZERO_EN
        // Border windows are zeroed here so the rest of the path yields 0 naturally.
        gx_p1 <= zero_p0 ? '0 : gx_c;
        gy_p1 <= zero_p0 ? '0 : gy_c;
`else
        gx_p1 <= gx_c;
        gy_p1 <= gy_c;
`endif
        mx_p2 <= sat_mag(gx_p1);
        my_p2 <= sat_mag(gy_p1);
        sx_p3 <= square(mx_p2);
        sy_p3 <= square(my_p2);
    end

    // ---- S4: sum of squares to output; o_data holds between results ----
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vld_p1       <= 1'b0;
            vld_p2       <= 1'b0;
            vld_p3       <= 1'b0;
            o_data_ready <= 1'b0;
            o_data       <= '0;
        end else begin
            vld_p1       <= vld_p0;
            vld_p2       <= vld_p1;
            vld_p3       <= vld_p2;
            o_data_ready <= vld_p3;
            if (vld_p3) begin
                o_data <= sum_sq(sx_p3, sy_p3);
            end
        end
    end

endmodule
